reg_writeback_unit: RTL and testbench
=====================================

REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of write-back queue entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports alu_valid, alu_dest, alu_data as inputs of 1, 5 and 32 bits: the ALU result offer.
REQ-005 SHALL have port alu_ready, output, 1: the ALU offer is accepted this cycle.
REQ-006 SHALL have ports mem_valid, mem_dest, mem_data as inputs of 1, 5 and 32 bits: the load result offer.
REQ-007 SHALL have port mem_ready, output, 1: the load offer is accepted this cycle.
REQ-008 SHALL have ports issue_valid and issue_dest as inputs of 1 and 5 bits: decode marks a destination as pending.
REQ-009 SHALL have ports qa and qb as inputs of 5 bits each, and ports busy_a and busy_b as outputs of 1 bit each: scoreboard query of source registers.
REQ-010 SHALL have ports wEnable, dR and wData as outputs of 1, 5 and 32 bits, driving the register-file write port.
REQ-011 SHALL have port full, output, 1, and port count, output, clog2(DEPTH)+1 bits: queue status.

Function
REQ-012 SHALL accept an offer on a rising edge when valid and ready are both high; accepted {dest, data} are appended to a FIFO.
REQ-013 SHALL compute free slots from the registered count only; a same-cycle drain SHALL NOT create extra free slots.
REQ-014 SHALL drive mem_ready = (free >= 1).
REQ-015 SHALL drive alu_ready = (free >= 2) or (free == 1 and not mem_valid); when only one slot is free, MEM has priority.
REQ-016 SHALL enqueue the MEM entry ahead of the ALU entry when both are accepted in the same cycle.
REQ-017 SHALL accept an offer with dest == 0 (handshake completes) but SHALL NOT enqueue it; register 0 is never written.
REQ-018 SHALL drive wEnable = FIFO non-empty, and dR/wData = head entry, combinationally from registered state; the head pops on each edge where wEnable is high.
REQ-019 SHALL give a latency of exactly one cycle from acceptance edge to wEnable high when the FIFO is empty.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; simultaneous push and pop at full or empty SHALL keep the count consistent.
REQ-021 SHALL keep a 32-bit pending vector: set bit issue_dest on an edge with issue_valid (bit 0 never set), and clear bit dR on an edge with wEnable.
REQ-022 SHALL let set win when set and clear hit the same register on the same edge.
REQ-023 SHALL drive busy_a = pending[qa] and busy_b = pending[qb], combinationally, with no write-through bypass.
REQ-024 SHALL drive full = (count == DEPTH).

Reset
REQ-025 SHALL, while rst_n is low, force count = 0, both pointers = 0 and pending = 0; wEnable, full, busy_a and busy_b SHALL read 0, and alu_ready/mem_ready SHALL read 1.
REQ-026 SHALL discard queued entries when reset asserts mid-operation, with no partial write issued.

Structure
REQ-027 SHALL place the register-index width (5), data width (32) and register count (32) in the shared cpu package.
REQ-028 SHALL implement the queue as one sub-module, wb_fifo, with dual push ordered MEM-then-ALU and a single pop.

Verification
REQ-029 Single ALU result: alu dest=5, data=0xDEADBEEF, FIFO empty -> next cycle wEnable=1, dR=5, wData=0xDEADBEEF; the cycle after, wEnable=0.
REQ-030 Dual offer: alu (3, 0x11) and mem (4, 0x22) offered together, 4 slots free -> both accepted; dR sequence is 4 then 3 on consecutive cycles.
REQ-031 One slot left: count=3, both valid -> mem_ready=1, alu_ready=0; ALU is accepted the following cycle.
REQ-032 Scoreboard: issue dest=7, then qa=7 -> busy_a=1 until the edge writing dR=7, then 0; issue dest=7 on that same edge -> busy_a stays 1.
REQ-033 Zero register: mem dest=0 offered -> mem_ready=1 and no wEnable; issue dest=0 -> busy for qa=0 stays 0.
REQ-034 Reset mid-queue: count=3, rst_n pulled low asynchronously -> count=0 and wEnable=0 immediately; no writes after release.

Source files
------------

// File: rtl/reg_writeback_unit_pkg.sv
// Shared CPU constants and the write-back queue entry layout.
package reg_writeback_unit_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 32;

    // One queued register-file write.
    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_wb_fifo.sv
// Write-back queue: up to two pushes per cycle (slot 0 first), one pop.
module wb_fifo
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push0_i,
    input  wb_entry_t               entry0_i,
    input  logic                    push1_i,
    input  wb_entry_t               entry1_i,
    input  logic                    pop_i,
    output wb_entry_t               head_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wr_idx1;
    logic                   do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // Second push lands after the first when both are present.
    assign wr_idx1 = wr_ptr_q + PTR_W'(push0_i);

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(do_pop);
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_ptr_q] <= entry0_i;
        if (push1_i) mem_q[wr_idx1]  <= entry1_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and load results into the register-file write port and
// tracks pending destinations for operand hazard queries.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [REG_IDX_W-1:0]   alu_dest,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [REG_IDX_W-1:0]   mem_dest,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   issue_valid,
    input  logic [REG_IDX_W-1:0]   issue_dest,
    input  logic [REG_IDX_W-1:0]   qa,
    input  logic [REG_IDX_W-1:0]   qb,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic                   wEnable,
    output logic [REG_IDX_W-1:0]   dR,
    output logic [DATA_W-1:0]      wData,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]    count_w;
    logic [CNT_W-1:0]    free_c;
    logic                push_mem, push_alu, empty_w;
    wb_entry_t           mem_entry, alu_entry, head_w;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // Free slots come from registered occupancy only; a same-cycle pop
    // never grants extra room.
    assign free_c    = CNT_W'(DEPTH) - count_w;
    assign mem_ready = (free_c >= CNT_W'(1));
    assign alu_ready = (free_c >= CNT_W'(2)) || ((free_c == CNT_W'(1)) && !mem_valid);

    // Register 0 offers complete the handshake but are dropped.
    assign push_mem  = mem_valid && mem_ready && (mem_dest != '0);
    assign push_alu  = alu_valid && alu_ready && (alu_dest != '0);
    assign mem_entry = '{dest: mem_dest, data: mem_data};
    assign alu_entry = '{dest: alu_dest, data: alu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push0_i  (push_mem),
        .entry0_i (mem_entry),
        .push1_i  (push_alu),
        .entry1_i (alu_entry),
        .pop_i    (wEnable),
        .head_o   (head_w),
        .empty_o  (empty_w),
        .count_o  (count_w)
    );

    assign wEnable = !empty_w;
    assign dR      = head_w.dest;
    assign wData   = head_w.data;
    assign full    = (count_w == CNT_W'(DEPTH));
    assign count   = count_w;

    // Pending update: clear on write-back first so a same-edge issue wins.
    always_comb begin
        pending_d = pending_q;
        if (wEnable) pending_d[dR] = 1'b0;
        if (issue_valid && (issue_dest != '0)) pending_d[issue_dest] = 1'b1;
    end

    // Pending vector state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign busy_a = pending_q[qa];
    assign busy_b = pending_q[qb];

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench with an expected-write queue checked by a negedge monitor.
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_dest, mem_dest, issue_dest, qa, qb;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, busy_a, busy_b, wEnable, full;
    logic [4:0]  dR;
    logic [31:0] wData;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;
    wb_entry_t exp_q [$];

    always #5 clk = ~clk;

    reg_writeback_unit #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .qa(qa), .qb(qb), .busy_a(busy_a), .busy_b(busy_b),
        .wEnable(wEnable), .dR(dR), .wData(wData),
        .full(full), .count(count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] d, input logic [31:0] v);
        exp_q.push_back('{dest: d, data: v});
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    endtask

    // Every presented write must match the oldest expected entry.
    always @(negedge clk) begin
        if (wEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: got dR=%0d wData=0x%0h expected none at %0t",
                         dR, wData, $time);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                chk("mon_dR", 32'(dR), 32'(e.dest));
                chk("mon_wData", wData, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        alu_dest = '0; mem_dest = '0; issue_dest = '0; qa = '0; qb = '0;
        alu_data = '0; mem_data = '0;
        #2;
        chk("rst_wEnable", 32'(wEnable), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_alu_ready", 32'(alu_ready), 1);
        chk("rst_mem_ready", 32'(mem_ready), 1);
        chk("rst_busy", 32'({busy_a, busy_b}), 0);
        tick(); tick();
        rst_n = 1'b1;

        // Single ALU result, one-cycle latency.
        tick();
        alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("t1_alu_ready", 32'(alu_ready), 1);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick(); idle_inputs();
        #1 chk("t1_wEnable_hi", 32'(wEnable), 1);
        chk("t1_dR", 32'(dR), 5);
        tick();
        #1 chk("t1_wEnable_lo", 32'(wEnable), 0);

        // Dual offer, MEM drains first.
        tick();
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_dest = 5'd4; mem_data = 32'h22;
        #1 chk("t2_ready", 32'({alu_ready, mem_ready}), 32'b11);
        expect_wr(5'd4, 32'h22); expect_wr(5'd3, 32'h11);
        tick(); idle_inputs();
        #1 chk("t2_dR_first", 32'(dR), 4);
        chk("t2_count", 32'(count), 2);
        tick();
        #1 chk("t2_dR_second", 32'(dR), 3);
        tick();
        #1 chk("t2_empty", 32'(wEnable), 0);

        // Build up to count=3, then one free slot with both offering.
        alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_dest = 5'd11; mem_data = 32'hB0;
        expect_wr(5'd11, 32'hB0); expect_wr(5'd10, 32'hA0);
        tick();
        alu_dest = 5'd12; alu_data = 32'hA1; mem_dest = 5'd13; mem_data = 32'hB1;
        #1 chk("t3_ready_at2", 32'({alu_ready, mem_ready}), 32'b11);
        expect_wr(5'd13, 32'hB1); expect_wr(5'd12, 32'hA1);
        tick();
        alu_dest = 5'd14; alu_data = 32'hA2; mem_dest = 5'd15; mem_data = 32'hB2;
        #1 chk("t3_count3", 32'(count), 3);
        chk("t3_full", 32'(full), 0);
        chk("t3_mem_ready", 32'(mem_ready), 1);
        chk("t3_alu_ready", 32'(alu_ready), 0);
        expect_wr(5'd15, 32'hB2);
        tick();
        mem_valid = 1'b0;
        #1 chk("t3_alu_ready_next", 32'(alu_ready), 1);
        expect_wr(5'd14, 32'hA2);
        tick(); idle_inputs();
        for (int i = 0; i < 20 && wEnable; i++) tick();
        chk("t3_drained", 32'(count), 0);

        // Scoreboard set / clear / set-wins.
        qa = 5'd7; qb = 5'd9;
        issue_valid = 1'b1; issue_dest = 5'd7;
        #1 chk("t4_no_bypass", 32'(busy_a), 0);
        tick(); idle_inputs();
        #1 chk("t4_busy_set", 32'({busy_a, busy_b}), 32'b10);
        alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h77;
        expect_wr(5'd7, 32'h77);
        tick(); idle_inputs();
        #1 chk("t4_busy_until_write", 32'(busy_a), 1);
        tick();
        #1 chk("t4_busy_cleared", 32'(busy_a), 0);
        issue_valid = 1'b1; issue_dest = 5'd7;
        tick(); idle_inputs();
        alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h78;
        expect_wr(5'd7, 32'h78);
        tick(); idle_inputs();
        issue_valid = 1'b1; issue_dest = 5'd7;
        #1 chk("t4_write_cycle", 32'({wEnable, dR}), 32'({1'b1, 5'd7}));
        tick(); idle_inputs();
        #1 chk("t4_set_wins", 32'(busy_a), 1);

        // Register 0 is never queued or marked busy.
        qa = 5'd0;
        mem_valid = 1'b1; mem_dest = 5'd0; mem_data = 32'h55;
        issue_valid = 1'b1; issue_dest = 5'd0;
        #1 chk("t5_mem_ready", 32'(mem_ready), 1);
        tick(); idle_inputs();
        #1 chk("t5_no_write", 32'(wEnable), 0);
        chk("t5_busy_r0", 32'(busy_a), 0);

        // Asynchronous reset with entries queued.
        qa = 5'd7;
        alu_valid = 1'b1; alu_dest = 5'd20; alu_data = 32'hC0;
        mem_valid = 1'b1; mem_dest = 5'd21; mem_data = 32'hD0;
        expect_wr(5'd21, 32'hD0); expect_wr(5'd20, 32'hC0);
        tick();
        alu_dest = 5'd22; alu_data = 32'hC1; mem_dest = 5'd23; mem_data = 32'hD1;
        expect_wr(5'd23, 32'hD1); expect_wr(5'd22, 32'hC1);
        tick(); idle_inputs();
        #1 chk("t6_count3", 32'(count), 3);
        rst_n = 1'b0;
        exp_q.delete();
        #1 chk("t6_count_rst", 32'(count), 0);
        chk("t6_wEnable_rst", 32'(wEnable), 0);
        chk("t6_ready_rst", 32'({alu_ready, mem_ready}), 32'b11);
        chk("t6_busy_rst", 32'(busy_a), 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t6_no_writes", 32'(wEnable), 0);
        chk("end_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
